// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses SYNC/LEN/PAYLOAD/CSUM frames from a byte stream.
// Payload is held in a FIFO and becomes readable only once its checksum verifies.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int MAX_LEN = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done,
  output logic [7:0] frame_len,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [7:0] MAX_L = 8'(MAX_LEN);
  localparam logic [PW-1:0] DEPTH = PW'(FIFO_DEPTH);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CSUM} state_t;
  state_t state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, free;
  logic [7:0] csum, len, remaining;
  logic [TW-1:0] timer;
  logic in_valid_q, byte_stb, expired, len_bad, len_nospace, err_hit;
  logic [1:0] err_cause;
  assign byte_stb = in_valid & ~in_valid_q;
  assign free = DEPTH - (wr_ptr - rd_ptr);
  assign out_valid = commit_ptr != rd_ptr;
  assign out_data = mem[rd_ptr[AW-1:0]];
  assign busy = state != HUNT;
  assign expired = busy && !byte_stb && timer == T_LAST;
  assign len_bad = in_data > MAX_L;
  assign len_nospace = 32'(in_data) > 32'(free);
  // a byte strobe in the expiry cycle takes priority over the timeout
  assign err_hit = byte_stb ? (state == LEN && (len_bad || len_nospace)) || (state == CSUM && in_data != csum) : expired;
  assign err_cause = !byte_stb ? 2'd3 : state == CSUM ? 2'd2 : len_bad ? 2'd0 : 2'd1;
  always_ff @(posedge clk)
    if (byte_stb && state == PAYLOAD) mem[wr_ptr[AW-1:0]] <= in_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HUNT;
      wr_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
      in_valid_q <= 1'b0;
      timer <= '0;
      csum <= '0;
      len <= '0;
      remaining <= '0;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
      frame_len <= '0;
      err_code <= '0;
    end else begin
      in_valid_q <= in_valid;
      frame_done <= 1'b0;
      frame_err <= err_hit;
      if (out_valid && out_ready) rd_ptr <= rd_ptr + PW'(1);
      timer <= (byte_stb || !busy) ? '0 : timer + TW'(1);
      if (err_hit) begin
        wr_ptr <= commit_ptr;
        err_code <= err_cause;
        state <= HUNT;
      end else if (byte_stb)
        case (state)
          HUNT: if (in_data == SYNC_BYTE) state <= LEN;
          LEN: begin
            state <= in_data == 8'd0 ? CSUM : PAYLOAD;
            len <= in_data;
            remaining <= in_data;
            csum <= in_data;
          end
          PAYLOAD: begin
            wr_ptr <= wr_ptr + PW'(1);
            csum <= csum + in_data;
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) state <= CSUM;
          end
          default: begin
            commit_ptr <= wr_ptr;
            frame_done <= 1'b1;
            frame_len <= len;
            state <= HUNT;
          end
        endcase
    end
endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Frame-level controller behind the UART byte receiver.
- Consumes received bytes and hunts for a sync byte, then parses length, payload and checksum.
- Buffers the payload in an internal FIFO and releases it to a ready/valid stream only after the checksum verifies.
- Bad, oversized or stalled frames are discarded by rolling back the FIFO write pointer.

Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- MAX_LEN, 16: largest legal payload length in bytes (1..255).
- FIFO_DEPTH, 16: payload buffer entries; power of two, >= MAX_LEN.
- TIMEOUT, 1024: max clk cycles between byte strobes inside a frame (>= 2).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8  received byte; stable whenever in_valid is high.
- in_valid  input  1  byte-valid level; may stay high for several cycles per byte.
- out_data  output  8  payload byte at FIFO head.
- out_valid  output  1  committed payload byte available.
- out_ready  input  1  downstream accepts out_data.
- frame_done  output  1  one-cycle pulse: frame committed.
- frame_len  output  8  length of last committed frame.
- frame_err  output  1  one-cycle pulse: frame discarded.
- err_code  output  2  cause of last discard: 0 BADLEN, 1 NOSPACE, 2 CSUM, 3 TIMEOUT.
- busy  output  1  state != HUNT.

Behaviour:
- Reset (asynchronous): state HUNT; all FIFO pointers 0; in_valid_q=0; timer 0. Outputs out_valid=0, frame_done=0, frame_err=0, frame_len=0, err_code=0, busy=0. Reset mid-frame discards the partial frame and any undrained committed data.
- Byte strobe: byte_stb = in_valid & ~in_valid_q, where in_valid_q is in_valid registered. One byte is accepted per rising edge. A held level never produces a second byte.
- FIFO pointers: wr_ptr, commit_ptr and rd_ptr, each clog2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH.
  - committed = commit_ptr - rd_ptr.
  - free = FIFO_DEPTH - (wr_ptr - rd_ptr).
- Read side:
  - out_valid = (committed != 0); out_data = mem[rd_ptr] (combinational read).
  - rd_ptr increments when out_valid & out_ready.
  - Read side is independent of the parser; a read and a write/commit/rollback in the same cycle are all legal.
- Checksum: csum = 8-bit running sum mod 256 of the LEN byte and all payload bytes. The SYNC byte is not included.
- State machine (transitions on byte_stb unless noted):
  - HUNT: byte == SYNC_BYTE -> LEN; any other byte is ignored.
  - LEN:
    - len > MAX_LEN -> error BADLEN, go HUNT.
    - len > free -> error NOSPACE, go HUNT.
    - len == 0 -> CSUM.
    - Otherwise -> PAYLOAD, with remaining=len and csum=len.
  - PAYLOAD: write mem[wr_ptr]; wr_ptr++; csum += byte; remaining--. Go CSUM when remaining reaches 0.
  - CSUM:
    - byte == csum: commit_ptr <= wr_ptr; frame_done pulses next cycle; frame_len <= len.
    - Otherwise: error CSUM.
    - Either way, go HUNT.
- Error action: wr_ptr <= commit_ptr (rollback); frame_err pulses the cycle after the error edge; err_code updates on that same edge and holds until the next error.
- Timeout:
  - Timer cleared on every byte_stb and while in HUNT; otherwise increments each cycle.
  - Timer reaching TIMEOUT-1 outside HUNT -> error TIMEOUT, go HUNT.
  - A byte_stb in the same cycle as expiry wins: the byte is processed and the timer clears.
- Latency: the checksum byte is accepted on edge N. Committed data is visible (out_valid=1) and frame_done=1 in cycle N+1.
- Committed data is never lost to a later error. Rollback affects uncommitted entries only.
- A SYNC_BYTE value inside LEN/PAYLOAD/CSUM is treated as data; there is no resync mid-frame.

Test Plan:
- Good frame: bytes A5 03 10 20 30 63, out_ready=1 -> one frame_done, frame_len=3, out stream 10,20,30, no frame_err.
- Bad checksum: A5 02 11 22 00 -> frame_err, err_code=2, out_valid never asserts, wr_ptr back at commit_ptr; a following good frame streams correctly.
- Oversize and held strobe:
  - A5 11 (17 > MAX_LEN) -> err_code=0, state HUNT.
  - in_valid held 8 cycles for a single byte A5 then 00 00 -> exactly one zero-length frame, frame_done, frame_len=0.
- Backpressure: out_ready=0, then A5 0A + 10 bytes + csum -> committed 10; then A5 0A -> err_code=1 (free=6). After draining 10 bytes, the same frame commits.
- Timeout: A5 04 AA then silence for TIMEOUT cycles -> frame_err with err_code=3, busy drops; a byte arriving exactly at cycle TIMEOUT-1 keeps the frame alive instead.
- Reset mid-payload with committed data pending -> out_valid=0 and busy=0 immediately; the next good frame streams correctly from empty.
